// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: decouples instruction-cache fetch groups from decode.
// Fetch groups of up to FETCH_WIDTH words enter a DEPTH-entry circular
// queue. The N_ISSUE oldest entries are presented to decode in program order.
// Optional feature macro: IFQ_BYPASS_EN. When it is defined and the queue is
// empty, an incoming group drives the issue lanes in the same cycle.
`timescale 1ns/1ps
module inst_fetch_queue #(
  parameter int FETCH_WIDTH = 2,
  parameter int N_ISSUE     = 2,
  parameter int DEPTH       = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              fetch_valid,
  input  logic [31:0]                       fetch_vaddr,
  input  logic [$clog2(FETCH_WIDTH):0]      fetch_count,
  input  logic [FETCH_WIDTH*32-1:0]         fetch_inst,
  input  logic [2:0]                        fetch_iaddr_ex,
  output logic                              fetch_ready,
  output logic [N_ISSUE-1:0]                issue_valid,
  output logic [N_ISSUE*32-1:0]             issue_vaddr,
  output logic [N_ISSUE*32-1:0]             issue_inst,
  output logic [N_ISSUE*3-1:0]              issue_iaddr_ex,
  input  logic [$clog2(N_ISSUE):0]          issue_count,
  output logic [$clog2(DEPTH):0]            occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] vaddr;
    logic [31:0] inst;
    logic [2:0]  ex;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;

  entry_t          in_word [FETCH_WIDTH];
  entry_t          wr_word [FETCH_WIDTH];
  entry_t          lane;
  logic            push, bypass;
  logic [CW-1:0]   n_push, n_avail, n_pop, n_skip, n_write, ic_ext;

  // Build the candidate entries of the incoming group and the push/pop amounts.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      in_word[k] = '{vaddr: fetch_vaddr + 32'(4 * k),
                     inst:  fetch_inst[32*k +: 32],
                     ex:    3'b000};
    end
    // A faulting group collapses to a single marker entry.
    if (|fetch_iaddr_ex) begin
      in_word[0] = '{vaddr: fetch_vaddr, inst: 32'h0, ex: fetch_iaddr_ex};
    end

    fetch_ready = (CW'(DEPTH) - count_q) >= CW'(FETCH_WIDTH);
    push        = fetch_valid & fetch_ready & ~flush;
    n_push      = '0;
    if (push) begin
      n_push = (|fetch_iaddr_ex) ? CW'(1) : CW'(fetch_count);
    end

`ifdef IFQ_BYPASS_EN
    bypass = push && (count_q == '0);
`else
    bypass = 1'b0;
`endif

    // Lanes come from the incoming group when bypassing, otherwise from storage.
    if (bypass) begin
      n_avail = (n_push < CW'(N_ISSUE)) ? n_push : CW'(N_ISSUE);
    end else begin
      n_avail = (count_q < CW'(N_ISSUE)) ? count_q : CW'(N_ISSUE);
    end

    // Over-consumption is clamped to the lanes actually valid.
    ic_ext  = CW'(issue_count);
    n_pop   = '0;
    if (!flush) begin
      n_pop = (ic_ext > n_avail) ? n_avail : ic_ext;
    end
    // Bypassed words consumed this cycle never reach storage.
    n_skip  = bypass ? n_pop : '0;
    n_write = n_push - n_skip;

    for (int k = 0; k < FETCH_WIDTH; k++) begin
      wr_word[k] = '0;
      for (int j = 0; j < FETCH_WIDTH; j++) begin
        if (CW'(j) == CW'(k) + n_skip) wr_word[k] = in_word[j];
      end
    end

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PW'(n_pop - n_skip);
      tail_d  = tail_q + PW'(n_write);
      count_d = count_q + n_push - n_pop;
    end
  end

  // Pointer and occupancy registers.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage write; a group may straddle the array end.
  // NOTE: the storage array is not reset; entries are only read when count covers them.
  always_ff @(posedge clk) begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (CW'(k) < n_write) mem_q[tail_q + PW'(k)] <= wr_word[k];
    end
  end

  // Issue lanes: entry head+i when valid, all-zero otherwise.
  always_comb begin
    issue_valid    = '0;
    issue_vaddr    = '0;
    issue_inst     = '0;
    issue_iaddr_ex = '0;
    lane           = '0;
    for (int i = 0; i < N_ISSUE; i++) begin
      lane = mem_q[head_q + PW'(i)];
      if (bypass) begin
        lane = '0;
        for (int j = 0; j < FETCH_WIDTH; j++) begin
          if (j == i) lane = in_word[j];
        end
      end
      if (CW'(i) < n_avail) begin
        issue_valid[i]           = 1'b1;
        issue_vaddr[32*i +: 32]  = lane.vaddr;
        issue_inst[32*i +: 32]   = lane.inst;
        issue_iaddr_ex[3*i +: 3] = lane.ex;
      end
    end
  end

  assign occupancy = count_q;

  // Decode must never consume more lanes than are valid.
  ic_not_over_valid: assert property (@(posedge clk) disable iff (rst)
    !flush |-> (CW'(issue_count) <= n_avail))
    else $error("issue_count %0d exceeds valid lanes %0d", issue_count, n_avail);

endmodule
